// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry once, emitting a zero-write strobe and address.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A request arriving while clearing is ignored; only rst restarts the walk.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) state_nxt = IDLE;
         end
      endcase
   end

   assign busy     = (state == CLEAR);
   assign clr_we   = busy && !rst;
   assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with write-through bypass and a clear sequencer.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic [DATA_W-1:0]        wdata1,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              zero_en;
   logic              wr0_ok, wr1_ok;

   regfile_clr_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign zero_en = (ZERO_REG != 0);
   assign wr0_ok  = we0 && !busy && !rst && !(zero_en && (waddr0 == '0));
   assign wr1_ok  = we1 && !busy && !rst && !(zero_en && (waddr1 == '0));

   // Port 1 is assigned last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         if (wr0_ok) mem[waddr0] <= wdata0;
         if (wr1_ok) mem[waddr1] <= wdata1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = raddr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd = '0;
         if (!rst && !busy && re[k] && !(zero_en && (ra == '0))) begin
            if (wr1_ok && (waddr1 == ra))      rd = wdata1;
            else if (wr0_ok && (waddr0 == ra)) rd = wdata0;
            else                               rd = mem[ra];
         end
      end

      assign rdata[k*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        we0, we1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        clr_req;
   logic        busy;

   regfile_mp #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_RD   (2),
      .ZERO_REG (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we0     (we0),
      .we1     (we1),
      .waddr0  (waddr0),
      .waddr1  (waddr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .re      (re),
      .raddr   (raddr),
      .rdata   (rdata),
      .clr_req (clr_req),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: contents plus the number of clear cycles still outstanding.
   logic [31:0] m_mem [32];
   int          m_left;
   int          checks;
   int          errors;
   bit          started;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int k);
      logic [4:0] a;
      logic       idle_now;
      a        = raddr[k*5 +: 5];
      idle_now = !rst && (m_left == 0);
      if (!idle_now || !re[k] || a == 5'd0) return 32'd0;
      if (we1 && waddr1 != 5'd0 && waddr1 == a) return wdata1;
      if (we0 && waddr0 != 5'd0 && waddr0 == a) return wdata0;
      return m_mem[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_left = 32;
         for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         if (we0 && waddr0 != 5'd0) m_mem[waddr0] = wdata0;
         if (we1 && waddr1 != 5'd0) m_mem[waddr1] = wdata1;
         if (clr_req) begin
            m_left = 32;
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
         end
      end
   endtask

   // Compare outputs mid-cycle, then advance one clock; inputs change only at negedge.
   task automatic tick();
      #1;
      if (started) begin
         check_val("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
         for (int k = 0; k < 2; k++)
            check_val($sformatf("rdata%0d", k), {32'd0, rdata[k*32 +: 32]}, {32'd0, exp_rd(k)});
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 1'b0; we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic read_all();
      re = 2'b11;
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         tick();
      end
   endtask

   int n;

   initial begin
      checks = 0; errors = 0; started = 0; m_left = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      quiet();
      waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; re = '0; raddr = '0;

      // Reset for one cycle, then the full clear must run.
      rst = 1'b1;
      @(negedge clk);
      tick();
      started = 1;
      rst = 1'b0;
      count_busy(n);
      check_val("rst_busy_len", 64'(n), 64'd32);
      read_all();

      // Write then read back, with same-cycle bypass on both ports.
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
      re = 2'b11; raddr = {5'd5, 5'd5};
      #1;
      check_val("bypass_p1", {32'd0, rdata[63:32]}, 64'hDEADBEEF);
      tick();
      quiet();
      #1;
      check_val("read_p0", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
      tick();

      // Collision on address 7: port 1 data must land.
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
      raddr = {5'd7, 5'd7};
      #1;
      check_val("coll_bypass", {32'd0, rdata[31:0]}, 64'h22);
      tick();
      quiet();
      #1;
      check_val("coll_read", {32'd0, rdata[31:0]}, 64'h22);
      tick();

      // Entry 0 is hardwired zero, bypass included.
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
      raddr = {5'd0, 5'd0};
      #1;
      check_val("zero_bypass", rdata, 64'd0);
      tick();
      quiet();
      #1;
      check_val("zero_read", rdata, 64'd0);
      tick();

      // Fill 1..31 with their index, then clear with a redundant request mid-way.
      for (int a = 1; a < 32; a++) begin
         we0 = 1'b1; waddr0 = 5'(a); wdata0 = 32'(a);
         tick();
      end
      quiet();
      read_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         we0 = 1'b1; waddr0 = 5'($urandom_range(1, 31)); wdata0 = $urandom;
         we1 = 1'b1; waddr1 = 5'($urandom_range(1, 31)); wdata1 = $urandom;
         clr_req = (n == 10);
         tick();
         n++;
      end
      quiet();
      check_val("clr_busy_len", 64'(n), 64'd32);
      read_all();

      // Reset 12 cycles into a clear restarts the full walk.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy(n);
      check_val("rst_mid_clr_len", 64'(n), 64'd32);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 149) == 0);
         clr_req = ($urandom_range(0, 79) == 0);
         we0     = $urandom_range(0, 1) == 1;
         we1     = $urandom_range(0, 1) == 1;
         waddr0  = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31));
         waddr1  = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
         wdata0  = $urandom;
         wdata1  = $urandom;
         re      = 2'($urandom_range(0, 3));
         raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr0 : 5'($urandom_range(0, 31));
         raddr[9:5] = ($urandom_range(0, 2) == 0) ? waddr1 : 5'($urandom_range(0, 31));
         tick();
      end
      quiet();
      for (int i = 0; i < 40; i++) tick();
      read_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each register entry.
REQ-002 SHALL have parameter ADDR_W, default 5; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have ports we0/we1  input  1 each  write enables, port 0 and port 1.
REQ-008 SHALL have ports waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_W each  write data.
REQ-010 SHALL have port re  input  NUM_RD  per-port read enables.
REQ-011 SHALL have port raddr  input  NUM_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata  output  NUM_RD*DATA_W  read data, port k in bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port clr_req  input  1  single-cycle request to zero the whole array.
REQ-014 SHALL have port busy  output  1  high while the clear sequence runs; reads/writes inactive.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, CLEAR; busy = (state == CLEAR), registered.
REQ-016 SHALL, in CLEAR, write zero to entry clr_cnt each cycle, increment clr_cnt, and go to IDLE on the edge where clr_cnt == DEPTH-1; clear takes exactly DEPTH cycles.
REQ-017 SHALL move IDLE -> CLEAR with clr_cnt = 0 on an edge where clr_req = 1; clr_req during CLEAR is ignored (no restart).
REQ-018 SHALL, in IDLE, write wdataN to entry waddrN on the edge when weN = 1; write latency one cycle.
REQ-019 SHALL, when both ports write the same address in one cycle, store wdata1 (port 1 wins).
REQ-020 SHALL discard writes to address 0 when ZERO_REG = 1.
REQ-021 SHALL discard all writes while busy = 1 or rst = 1.
REQ-022 SHALL make each read port combinational: rdata[k] = 0 if rst, busy, re[k] = 0, or (ZERO_REG and raddr[k] = 0); else stored entry.
REQ-023 SHALL bypass same-cycle writes: if an accepted write in this cycle targets raddr[k], rdata[k] returns that wdata (wdata1 over wdata0).
REQ-024 SHALL allow any number of read ports to address the same entry simultaneously with identical results.

Reset
REQ-025 SHALL, on an edge with rst = 1, set state = CLEAR, clr_cnt = 0; busy = 1 from the following cycle.
REQ-026 SHALL hold rdata = 0 while rst = 1; array contents after reset are zero only once the clear sequence completes.
REQ-027 SHALL restart the clear from entry 0 if rst is asserted mid-clear.

Structure
REQ-028 SHALL place the FSM state type (IDLE, CLEAR) and default width constants in shared package regfile_pkg.
REQ-029 SHALL implement the clear FSM and counter as sub-module regfile_clr_fsm (outputs busy, clr_we, clr_addr); array, write arbitration and read/bypass muxes stay in regfile_mp.

Verification
REQ-030 SHALL test reset: rst 1 cycle -> busy = 1 for exactly 32 cycles (defaults), then 0; all 32 entries read 0.
REQ-031 SHALL test write/read: we0, waddr0 = 5, wdata0 = 0xDEADBEEF -> next cycle raddr[0] = 5, re[0] = 1 gives 0xDEADBEEF; same cycle bypass gives 0xDEADBEEF on port 1 reading 5.
REQ-032 SHALL test collision: we0/we1 both addr 7, data 0x11/0x22 -> entry 7 reads 0x22.
REQ-033 SHALL test zero register: we0, addr 0, data 0xFFFFFFFF -> rdata for addr 0 stays 0, bypass included.
REQ-034 SHALL test clear: fill entries 1..31 with index value, pulse clr_req -> busy 32 cycles, writes during busy dropped, all entries 0 afterwards; second clr_req at cycle 10 of clear does not extend busy.
REQ-035 SHALL test rst at cycle 12 of a clear -> busy stays high another 32 cycles from the rst edge.
